// File: rtl/cnn_pkg.sv
// Shared constants and helpers for the CNN streaming blocks: FSM state
// encoding and output-geometry derivation for convolution windows.
package cnn_pkg;

  // Streamer FSM encoding (kept as plain constants for legacy tooling).
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;

  // Output size along one axis for input size n, filter f, stride s, padding p.
  function automatic int calc_out_dim(input int n, input int f, input int s, input int p);
    return (n + 2 * p - f) / s + 1;
  endfunction

  // Beats needed to cover one output row when npar windows go out per beat.
  function automatic int calc_bpr(input int ow, input int npar);
    return (ow + npar - 1) / npar;
  endfunction

endpackage

// File: rtl/rf_window_gather.sv
// Combinational extraction of one D x F x F receptive field from a flattened
// image. Coordinates falling in the zero-padding border read as zero.
module rf_window_gather #(
  parameter int DATA_WIDTH = 16,
  parameter int D          = 1,
  parameter int H          = 32,
  parameter int W          = 32,
  parameter int F          = 5,
  parameter int S          = 1,
  parameter int P          = 0
) (
  input  logic [D*H*W*DATA_WIDTH-1:0] image,
  input  logic [7:0]                  row,
  input  logic [15:0]                 col,
  output logic [D*F*F*DATA_WIDTH-1:0] window
);

  localparam int NPIX = D * H * W;
  localparam int NWIN = D * F * F;

  // Walk channel/filter-row/filter-column, mapping each tap to an image pixel.
  always_comb begin
    int r;
    int x;
    int src;
    int dst;
    r      = 0;
    x      = 0;
    src    = 0;
    dst    = 0;
    window = '0;
    for (int k = 0; k < D; k++) begin
      for (int i = 0; i < F; i++) begin
        for (int c = 0; c < F; c++) begin
          // Signed int math so the padded border goes negative instead of wrapping.
          r   = int'(row) * S - P + i;
          x   = int'(col) * S - P + c;
          dst = (NWIN - 1 - ((k * F + i) * F + c)) * DATA_WIDTH;
          if (r >= 0 && r < H && x >= 0 && x < W) begin
            src = (NPIX - 1 - ((k * H + r) * W + x)) * DATA_WIDTH;
            window[dst +: DATA_WIDTH] = image[src +: DATA_WIDTH];
          end
        end
      end
    end
  end

endmodule

// File: rtl/receptive_field_streamer.sv
// Scans a held image and streams NPAR convolution windows per beat, row by
// row, with zero padding and a partial final beat on each output row.
//
// Handshake: a beat transfers on any rising edge where out_valid && out_ready.
// While out_valid is high and out_ready is low, every beat output is held.
// out_valid never drops without a transfer, except under reset.
module receptive_field_streamer
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int D          = 1,
  parameter int H          = 32,
  parameter int W          = 32,
  parameter int F          = 5,
  parameter int S          = 1,
  parameter int P          = 0,
  parameter int NPAR       = 14
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [D*H*W*DATA_WIDTH-1:0]       image,
  input  logic                              start,
  input  logic                              out_ready,
  output logic                              out_valid,
  output logic [NPAR*D*F*F*DATA_WIDTH-1:0]  receptive_field,
  output logic [NPAR-1:0]                   lane_valid,
  output logic [7:0]                        out_row,
  output logic [7:0]                        out_col,
  output logic                              out_last,
  output logic                              busy,
  output logic                              done,
  output logic [1:0]                        dbg_state
);

  localparam int OH       = calc_out_dim(H, F, S, P);
  localparam int OW       = calc_out_dim(W, F, S, P);
  localparam int BPR      = calc_bpr(OW, NPAR);
  localparam int WIN      = D * F * F * DATA_WIDTH;
  localparam int LAST_COL = (BPR - 1) * NPAR;

  if (OH > 256 || OW > 256 || S > F || S < 1 || P >= F || P < 0) begin : g_bad_geometry
    $error("receptive_field_streamer: unsupported geometry (OH/OW > 256, S outside 1..F or P >= F)");
  end

  logic [1:0]           state;
  logic [WIN-1:0]       lane_win [NPAR];
  logic [15:0]          lane_col [NPAR];
  logic [NPAR*WIN-1:0]  rf_next;
  logic [NPAR-1:0]      lv_next;
  logic                 last_next;

  assign dbg_state = state;

  // One gather per lane; lane j sits NPAR-relative column j past out_col.
  for (genvar j = 0; j < NPAR; j++) begin : g_lane
    assign lane_col[j] = {8'd0, out_col} + 16'(j);
    rf_window_gather #(
      .DATA_WIDTH (DATA_WIDTH),
      .D          (D),
      .H          (H),
      .W          (W),
      .F          (F),
      .S          (S),
      .P          (P)
    ) u_gather (
      .image  (image),
      .row    (out_row),
      .col    (lane_col[j]),
      .window (lane_win[j])
    );
  end

  // Assemble the next beat: lanes past the row end are zero and marked invalid.
  always_comb begin
    rf_next = '0;
    lv_next = '0;
    for (int j = 0; j < NPAR; j++) begin
      if (int'(out_col) + j < OW) begin
        rf_next[j*WIN +: WIN] = lane_win[j];
        lv_next[NPAR-1-j]     = 1'b1;
      end
    end
    last_next = (int'(out_row) == OH - 1) && (int'(out_col) == LAST_COL);
  end

  // Scan FSM: out_row/out_col double as the scan position of the pending beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= ST_IDLE;
      out_valid       <= 1'b0;
      receptive_field <= '0;
      lane_valid      <= '0;
      out_row         <= 8'd0;
      out_col         <= 8'd0;
      out_last        <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_LOAD;
            busy    <= 1'b1;
            out_row <= 8'd0;
            out_col <= 8'd0;
          end
        end
        ST_LOAD: begin
          receptive_field <= rf_next;
          lane_valid      <= lv_next;
          out_last        <= last_next;
          out_valid       <= 1'b1;
          state           <= ST_EMIT;
        end
        ST_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              state   <= ST_IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
              out_row <= 8'd0;
              out_col <= 8'd0;
            end else begin
              state <= ST_LOAD;
              if (int'(out_col) + NPAR >= OW) begin
                out_col <= 8'd0;
                out_row <= out_row + 8'd1;
              end else begin
                out_col <= out_col + 8'(NPAR);
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_receptive_field_streamer.sv
// Directed bench for receptive_field_streamer: three geometries (6x6 F3,
// 4x4 F3 padded, 6x6 F2 stride 2), stalls, start while busy, mid-scan reset.
module tb_receptive_field_streamer;

  localparam int DW = 16;

  int total;
  int bad;
  int sel;

  logic clk = 1'b0;
  logic reset;
  logic rdy;

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // instance A: 6x6, F=3, S=1, P=0, NPAR=2
  logic [36*DW-1:0]  image_a;
  logic              start_a;
  logic              valid_a, last_a, busy_a, done_a;
  logic [2*9*DW-1:0] rf_a;
  logic [1:0]        lv_a;
  logic [7:0]        row_a, col_a;
  logic [1:0]        st_a;

  // instance B: 4x4, F=3, S=1, P=1, NPAR=4
  logic [16*DW-1:0]  image_b;
  logic              start_b;
  logic              valid_b, last_b, busy_b, done_b;
  logic [4*9*DW-1:0] rf_b;
  logic [3:0]        lv_b;
  logic [7:0]        row_b, col_b;
  logic [1:0]        st_b;

  // instance C: 6x6, F=2, S=2, P=0, NPAR=2
  logic [36*DW-1:0]  image_c;
  logic              start_c;
  logic              valid_c, last_c, busy_c, done_c;
  logic [2*4*DW-1:0] rf_c;
  logic [1:0]        lv_c;
  logic [7:0]        row_c, col_c;
  logic [1:0]        st_c;

  receptive_field_streamer #(
    .DATA_WIDTH(DW), .D(1), .H(6), .W(6), .F(3), .S(1), .P(0), .NPAR(2)
  ) u_a (
    .clk(clk), .reset(reset), .image(image_a), .start(start_a), .out_ready(rdy),
    .out_valid(valid_a), .receptive_field(rf_a), .lane_valid(lv_a), .out_row(row_a),
    .out_col(col_a), .out_last(last_a), .busy(busy_a), .done(done_a), .dbg_state(st_a)
  );

  receptive_field_streamer #(
    .DATA_WIDTH(DW), .D(1), .H(4), .W(4), .F(3), .S(1), .P(1), .NPAR(4)
  ) u_b (
    .clk(clk), .reset(reset), .image(image_b), .start(start_b), .out_ready(rdy),
    .out_valid(valid_b), .receptive_field(rf_b), .lane_valid(lv_b), .out_row(row_b),
    .out_col(col_b), .out_last(last_b), .busy(busy_b), .done(done_b), .dbg_state(st_b)
  );

  receptive_field_streamer #(
    .DATA_WIDTH(DW), .D(1), .H(6), .W(6), .F(2), .S(2), .P(0), .NPAR(2)
  ) u_c (
    .clk(clk), .reset(reset), .image(image_c), .start(start_c), .out_ready(rdy),
    .out_valid(valid_c), .receptive_field(rf_c), .lane_valid(lv_c), .out_row(row_c),
    .out_col(col_c), .out_last(last_c), .busy(busy_c), .done(done_c), .dbg_state(st_c)
  );

  // selected-instance view used by the shared driver/scoreboard tasks
  logic         cur_valid, cur_last, cur_busy, cur_done;
  logic [575:0] cur_rf;
  logic [3:0]   cur_lv;
  logic [7:0]   cur_row, cur_col;
  logic [1:0]   cur_st;

  always_comb begin
    cur_valid = valid_a; cur_last = last_a; cur_busy = busy_a; cur_done = done_a;
    cur_rf = 576'(rf_a); cur_lv = 4'(lv_a); cur_row = row_a; cur_col = col_a; cur_st = st_a;
    case (sel)
      1: begin
        cur_valid = valid_b; cur_last = last_b; cur_busy = busy_b; cur_done = done_b;
        cur_rf = 576'(rf_b); cur_lv = lv_b; cur_row = row_b; cur_col = col_b; cur_st = st_b;
      end
      2: begin
        cur_valid = valid_c; cur_last = last_c; cur_busy = busy_c; cur_done = done_c;
        cur_rf = 576'(rf_c); cur_lv = 4'(lv_c); cur_row = row_c; cur_col = col_c; cur_st = st_c;
      end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [575:0] obs, input logic [575:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic set_start(input logic v);
    case (sel)
      1:       start_b = v;
      2:       start_c = v;
      default: start_a = v;
    endcase
  endtask

  task automatic pulse_start();
    @(negedge clk);
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
  endtask

  // reference window: pixel value is row*w+col, zero outside the image
  function automatic logic [143:0] exp_win(input int orow, input int ocol, input int h,
                                           input int w, input int f, input int s, input int p);
    logic [143:0] res;
    int r;
    int x;
    res = '0;
    for (int i = 0; i < f; i++) begin
      for (int c = 0; c < f; c++) begin
        r = orow * s - p + i;
        x = ocol * s - p + c;
        if (r >= 0 && r < h && x >= 0 && x < w)
          res[(f*f-1-(i*f+c))*16 +: 16] = 16'(r * w + x);
      end
    end
    return res;
  endfunction

  // scoreboard: expected beat keys {row, col, last, lane_valid} in scan order
  task automatic run_scan(input int h, input int w, input int f, input int s, input int p,
                          input int npar, input int exp_beats, input bit stall, input int poke_at);
    logic [20:0]  exp_q[$];
    logic [20:0]  key;
    logic [20:0]  got;
    logic [20:0]  held_meta;
    logic [575:0] held_rf;
    logic [143:0] m;
    logic [143:0] ew;
    logic [3:0]   lv;
    int oh, ow, win, beats, cyc, kc;
    bit stalled, poke_on, finished;
    oh  = (h + 2 * p - f) / s + 1;
    ow  = (w + 2 * p - f) / s + 1;
    win = f * f * DW;
    for (int r = 0; r < oh; r++) begin
      for (int c = 0; c < ow; c += npar) begin
        lv = '0;
        for (int j = 0; j < npar; j++) if (c + j < ow) lv[npar-1-j] = 1'b1;
        exp_q.push_back({8'(r), 8'(c), (r == oh - 1) && (c + npar >= ow), lv});
      end
    end
    beats = 0; cyc = 0; stalled = 0; poke_on = 0; finished = 0;
    held_rf = '0; held_meta = '0;
    while (!finished && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (poke_on) begin
        set_start(1'b0);
        poke_on = 0;
      end
      if (cur_valid) begin
        got = {cur_row, cur_col, cur_last, cur_lv};
        if (stalled) begin
          chk("stall_rf", cur_rf, held_rf);
          chk("stall_meta", 576'(got), 576'(held_meta));
        end
        rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rdy) begin
          stalled = 0;
          if (exp_q.size() == 0) begin
            chk("extra_beat", 576'(beats + 1), 576'(exp_beats));
            finished = 1;
          end else begin
            key = exp_q.pop_front();
            chk("beat_meta", 576'(got), 576'(key));
            kc = int'(key[12:5]);
            m  = '1;
            m  = m >> (144 - win);
            for (int j = 0; j < npar; j++) begin
              ew = (kc + j < ow) ? exp_win(int'(key[20:13]), kc + j, h, w, f, s, p) : '0;
              chk("lane_px", (cur_rf >> (j * win)) & 576'(m), 576'(ew));
            end
            beats++;
            if (beats == poke_at) begin
              set_start(1'b1);
              poke_on = 1;
            end
            if (key[4]) finished = 1;
          end
        end else begin
          stalled   = 1;
          held_rf   = cur_rf;
          held_meta = got;
        end
      end else if (stall) begin
        rdy = 1'($urandom_range(0, 1));
      end
    end
    chk("scan_finished", 576'(finished), 576'(1));
    chk("beat_count", 576'(beats), 576'(exp_beats));
    @(negedge clk);
    rdy = 1'b0;
    set_start(1'b0);
    chk("done_pulse", 576'(cur_done), 576'(1));
    chk("busy_after", 576'(cur_busy), 576'(0));
    @(negedge clk);
    chk("done_clear", 576'(cur_done), 576'(0));
    chk("idle_valid", 576'(cur_valid), 576'(0));
    @(negedge clk);
    chk("idle_busy", 576'(cur_busy), 576'(0));
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"}, 576'(cur_valid), 576'(0));
    chk({tag, "_rf"}, cur_rf, 576'(0));
    chk({tag, "_lv"}, 576'(cur_lv), 576'(0));
    chk({tag, "_row"}, 576'(cur_row), 576'(0));
    chk({tag, "_col"}, 576'(cur_col), 576'(0));
    chk({tag, "_last"}, 576'(cur_last), 576'(0));
    chk({tag, "_busy"}, 576'(cur_busy), 576'(0));
    chk({tag, "_done"}, 576'(cur_done), 576'(0));
    chk({tag, "_state"}, 576'(cur_st), 576'(0));
  endtask

  initial begin
    int n;
    int cyc;
    total = 0; bad = 0; sel = 0;
    rdy = 1'b0; reset = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    for (int idx = 0; idx < 36; idx++) begin
      image_a[(35-idx)*DW +: DW] = 16'(idx);
      image_c[(35-idx)*DW +: DW] = 16'(idx);
    end
    for (int idx = 0; idx < 16; idx++) image_b[(15-idx)*DW +: DW] = 16'(idx);

    // reset state on all three instances
    repeat (2) @(negedge clk);
    chk_zero_outputs("a_rst");
    sel = 1; #1;
    chk_zero_outputs("b_rst");
    sel = 2; #1;
    chk_zero_outputs("c_rst");
    sel = 0; #1;
    @(negedge clk);
    reset = 1'b1;

    // A: plain scan, first beat checked by hand
    pulse_start();
    chk("a_load_busy", 576'(cur_busy), 576'(1));
    chk("a_load_valid", 576'(cur_valid), 576'(0));
    chk("a_load_state", 576'(cur_st), 576'(1));
    @(negedge clk);
    chk("a_b0_valid", 576'(cur_valid), 576'(1));
    chk("a_b0_lane0", 576'(cur_rf[143:0]),
        576'({16'd0, 16'd1, 16'd2, 16'd6, 16'd7, 16'd8, 16'd12, 16'd13, 16'd14}));
    chk("a_b0_lv", 576'(cur_lv), 576'(4'b0011));
    run_scan(6, 6, 3, 1, 0, 2, 8, 1'b0, -1);

    // A: random back-pressure
    pulse_start();
    run_scan(6, 6, 3, 1, 0, 2, 8, 1'b1, -1);

    // A: start pulsed mid-scan must be ignored
    pulse_start();
    run_scan(6, 6, 3, 1, 0, 2, 8, 1'b0, 2);

    // B: padding, first window checked by hand
    sel = 1; #1;
    pulse_start();
    @(negedge clk);
    chk("b_b0_lane0", 576'(cur_rf[143:0]),
        576'({16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 16'd4, 16'd5}));
    chk("b_b0_lv", 576'(cur_lv), 576'(4'b1111));
    run_scan(4, 4, 3, 1, 1, 4, 4, 1'b0, -1);

    // C: stride 2, partial second beat per row
    sel = 2; #1;
    pulse_start();
    @(negedge clk);
    chk("c_b0_lane0", 576'(cur_rf[63:0]), 576'({16'd0, 16'd1, 16'd6, 16'd7}));
    run_scan(6, 6, 2, 2, 0, 2, 6, 1'b0, -1);

    // A: reset while beat 3 is presented, then a fresh scan
    sel = 0; #1;
    pulse_start();
    rdy = 1'b1;
    n = 0; cyc = 0;
    while (n < 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cur_valid && rdy) n++;
    end
    @(negedge clk);
    rdy = 1'b0;
    cyc = 0;
    while (!cur_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_b3_valid", 576'(cur_valid), 576'(1));
    chk("rst_b3_pos", 576'({cur_row, cur_col}), 576'({8'd1, 8'd2}));
    reset = 1'b0;
    #1;
    chk_zero_outputs("mid_rst");
    repeat (2) begin
      @(negedge clk);
      chk("mid_rst_hold_done", 576'(cur_done), 576'(0));
    end
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_done", 576'(cur_done), 576'(0));
    chk("post_rst_busy", 576'(cur_busy), 576'(0));
    pulse_start();
    @(negedge clk);
    chk("restart_pos", 576'({cur_valid, cur_row, cur_col}), 576'({1'b1, 8'd0, 8'd0}));
    run_scan(6, 6, 3, 1, 0, 2, 8, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
